// File: rtl/bit_deserializer_pkg.sv
// Shared types and sizing helpers for the bit-select link deserializer.
// Optional parity slot enabled by BIT_DESERIALIZER_PARITY_EN.
package bit_deserializer_pkg;

    typedef enum logic {FILL, FULL} state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Index of the final serial slot of a word (the parity slot when enabled).
    function automatic int last_slot(input int width);
`ifdef BIT_DESERIALIZER_PARITY_EN
        return width;
`else
        return width - 1;
`endif
    endfunction

    function automatic int cnt_width(input int width);
        return $clog2(last_slot(width) + 1);
    endfunction

endpackage

// File: rtl/bit_deserializer_slot_decoder.sv
// Index -> one-hot fill-register write enable; inverse of the transmitter's bit mux.
// Indices beyond WIDTH-1 (the parity slot) enable no data bit.
module bit_slot_decoder #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 0,
    parameter int IDX_W     = $clog2(WIDTH)
) (
    input  logic [IDX_W-1:0] idx,
    input  logic             en,
    output logic [WIDTH-1:0] we
);

    always_comb begin
        we = '0;
        for (int k = 0; k < WIDTH; k++) begin
            if (en && idx == IDX_W'(MSB_FIRST != 0 ? WIDTH - 1 - k : k))
                we[k] = 1'b1;
        end
    end

endmodule

// File: rtl/bit_deserializer.sv
// Serial bit stream -> parallel words with a one-word output buffer.
// Define BIT_DESERIALIZER_PARITY_EN for a trailing even-parity bit and parity_err output.
module bit_deserializer
    import bit_deserializer_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int CNT_W     = cnt_width(WIDTH),
    parameter int MSB_FIRST = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_bit,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [CNT_W-1:0] bit_idx,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
`ifdef BIT_DESERIALIZER_PARITY_EN
    ,
    output logic             parity_err
`endif
);

    state_t           state;
    logic [WIDTH-1:0] fill, fill_new, we;
    logic             accept, last, word_done, load_fill, load_held;

    assign in_ready  = (state == FILL);
    assign accept    = in_valid && in_ready && !clr;
    assign last      = (bit_idx == CNT_W'(last_slot(WIDTH)));
    assign word_done = accept && last;
    // Completed word goes straight out if the buffer is empty or draining now.
    assign load_fill = word_done && (!out_valid || out_ready);
    assign load_held = (state == FULL) && out_ready && !clr;

    bit_slot_decoder #(
        .WIDTH    (WIDTH),
        .MSB_FIRST(MSB_FIRST),
        .IDX_W    (CNT_W)
    ) u_dec (
        .idx(bit_idx),
        .en (accept),
        .we (we)
    );

    assign fill_new = (fill & ~we) | (we & {WIDTH{in_bit}});

`ifdef BIT_DESERIALIZER_PARITY_EN
    logic word_perr, perr_held;
    // On the last slot in_bit is the parity bit and fill already holds all data.
    assign word_perr = (^fill) ^ in_bit;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FILL;
            fill      <= '0;
            bit_idx   <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
`ifdef BIT_DESERIALIZER_PARITY_EN
            perr_held  <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            if (clr) begin
                bit_idx <= '0;
                state   <= FILL;
            end else if (accept) begin
                fill    <= fill_new;
                bit_idx <= last ? '0 : bit_idx + CNT_W'(1);
                if (word_done && !load_fill)
                    state <= FULL;
`ifdef BIT_DESERIALIZER_PARITY_EN
                if (word_done)
                    perr_held <= word_perr;
`endif
            end else if (load_held) begin
                state <= FILL;
            end

            if (load_fill) begin
                out_data  <= fill_new;
                out_valid <= 1'b1;
`ifdef BIT_DESERIALIZER_PARITY_EN
                parity_err <= word_perr;
`endif
            end else if (load_held) begin
                out_data  <= fill;
                out_valid <= 1'b1;
`ifdef BIT_DESERIALIZER_PARITY_EN
                parity_err <= perr_held;
`endif
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bit_deserializer.sv
// Directed bench: LSB-first and MSB-first deserializers fed the same serial stream.
module tb_bit_deserializer;

`ifdef BIT_DESERIALIZER_PARITY_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif

    logic       clk = 1'b0;
    logic       rst_n, clr, in_bit, in_valid, out_ready;
    logic       in_ready0, in_ready1, out_valid0, out_valid1;
    logic [7:0] out_data0, out_data1;
    logic [$clog2(NB)-1:0] bit_idx0, bit_idx1;
`ifdef BIT_DESERIALIZER_PARITY_EN
    logic       perr0, perr1;
`endif

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    bit_deserializer #(.WIDTH(8), .MSB_FIRST(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_bit(in_bit), .in_valid(in_valid),
        .in_ready(in_ready0), .bit_idx(bit_idx0), .out_data(out_data0),
        .out_valid(out_valid0), .out_ready(out_ready)
`ifdef BIT_DESERIALIZER_PARITY_EN
        , .parity_err(perr0)
`endif
    );

    bit_deserializer #(.WIDTH(8), .MSB_FIRST(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_bit(in_bit), .in_valid(in_valid),
        .in_ready(in_ready1), .bit_idx(bit_idx1), .out_data(out_data1),
        .out_valid(out_valid1), .out_ready(out_ready)
`ifdef BIT_DESERIALIZER_PARITY_EN
        , .parity_err(perr1)
`endif
    );

    typedef struct {
        logic [7:0] word;     // bit k is sent in serial slot k
        logic [7:0] exp_lsb;
        logic [7:0] exp_msb;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Serial slots first..last of a word; slot 8 is the parity bit.
    task automatic send_serial(input logic [7:0] w, input logic par, input int first, input int last);
        for (int k = first; k <= last; k++) begin
            in_valid = 1'b1;
            in_bit   = (k < 8) ? w[k] : par;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_bit   = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w);
        send_serial(w, ^w, 0, NB - 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic       in_ok;
        logic [7:0] pair [2];

        vecs[0] = '{8'h4D, 8'h4D, 8'hB2};
        vecs[1] = '{8'hA5, 8'hA5, 8'hA5};
        vecs[2] = '{8'h01, 8'h01, 8'h80};
        vecs[3] = '{8'h00, 8'h00, 8'h00};
        vecs[4] = '{8'h07, 8'h07, 8'hE0};

        rst_n = 1'b0; clr = 1'b0; in_bit = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset out_valid", out_valid0, 0);
        chk("reset out_data", out_data0, 0);
        chk("reset bit_idx", bit_idx0, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("in_ready after reset", in_ready0, 1);

        // Table: one word each, consumer always ready.
        foreach (vecs[i]) begin
            send_word(vecs[i].word);
            chk($sformatf("vec%0d out_valid", i), out_valid0, 1);
            chk($sformatf("vec%0d lsb out_data", i), out_data0, vecs[i].exp_lsb);
            chk($sformatf("vec%0d msb out_data", i), out_data1, vecs[i].exp_msb);
            chk($sformatf("vec%0d bit_idx", i), bit_idx0, 0);
        end
        @(posedge clk); #1;
        chk("handshake clears out_valid", out_valid0, 0);

        // Sustained stream A5, 3C: in_ready never drops.
        pair[0] = 8'hA5; pair[1] = 8'h3C;
        in_ok = 1'b1;
        for (int w = 0; w < 2; w++) begin
            for (int k = 0; k < NB; k++) begin
                if (!in_ready0) in_ok = 1'b0;
                send_serial(pair[w], ^pair[w], k, k);
            end
            chk($sformatf("b2b word%0d", w), out_data0, pair[w]);
            chk($sformatf("b2b valid%0d", w), out_valid0, 1);
        end
        chk("b2b in_ready steady", in_ok, 1);
        @(posedge clk); #1;

        // Simultaneous last-bit accept and handshake: no gap in out_valid.
        out_ready = 1'b0;
        send_word(8'hA5);
        send_serial(8'h3C, ^8'h3C, 0, NB - 2);
        chk("hold data stable", out_data0, 8'hA5);
        chk("hold valid", out_valid0, 1);
        out_ready = 1'b1;
        send_serial(8'h3C, ^8'h3C, NB - 1, NB - 1);
        chk("swap data", out_data0, 8'h3C);
        chk("swap valid no gap", out_valid0, 1);
        chk("swap in_ready", in_ready0, 1);
        @(posedge clk); #1;
        chk("swap drained", out_valid0, 0);

        // Backpressure into FULL.
        out_ready = 1'b0;
        send_word(8'hFF);
        send_word(8'h01);
        chk("full in_ready low", in_ready0, 0);
        chk("full out_data held", out_data0, 8'hFF);
        in_valid = 1'b1; in_bit = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("full ignores bits", bit_idx0, 0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("full release data", out_data0, 8'h01);
        chk("full release msb", out_data1, 8'h80);
        chk("full release valid", out_valid0, 1);
        chk("full release in_ready", in_ready0, 1);
        @(posedge clk); #1;
        chk("full drained", out_valid0, 0);

        // clr mid-word: presented word survives, partial word dropped.
        out_ready = 1'b0;
        send_word(8'h4D);
        send_serial(8'h07, 1'b1, 0, 2);
        clr = 1'b1; in_valid = 1'b1; in_bit = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0; in_valid = 1'b0;
        chk("clr bit_idx", bit_idx0, 0);
        chk("clr keeps out_valid", out_valid0, 1);
        chk("clr keeps out_data", out_data0, 8'h4D);
        out_ready = 1'b1;
        @(posedge clk); #1;
        send_word(8'h5A);
        chk("after clr data", out_data0, 8'h5A);
        chk("after clr msb", out_data1, 8'h5A);

        // Async reset mid-word with a word presented.
        out_ready = 1'b0;
        send_word(8'h3C);
        send_serial(8'hFF, 1'b0, 0, 3);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst out_valid", out_valid0, 0);
        chk("async rst out_data", out_data0, 0);
        chk("async rst bit_idx", bit_idx0, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        send_word(8'h4D);
        chk("post rst data", out_data0, 8'h4D);

`ifdef BIT_DESERIALIZER_PARITY_EN
        send_serial(8'h07, 1'b1, 0, NB - 1);
        chk("parity good err", perr0, 0);
        chk("parity good msb err", perr1, 0);
        chk("parity good data", out_data0, 8'h07);
        send_serial(8'h07, 1'b0, 0, NB - 1);
        chk("parity bad err", perr0, 1);
        chk("parity bad data", out_data0, 8'h07);
        chk("parity bad msb data", out_data1, 8'hE0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
